wr_flow_ctrl: RTL and testbench

WR_FLOW_CTRL -- requirements
Module: wr_flow_ctrl

---
 rtl/wr_flow_ctrl.sv | 177 +++++++++++++++++
 tb/tb_wr_flow_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_flow_ctrl.sv
// ---------------------------------------------------------------------------
// WrFlowCtrl -- write-side flow control for an asynchronous FIFO.
//
// Purpose:
//   Accepts words from an upstream valid/ready source into a two-entry
//   in-order skid buffer and drains them into the FIFO write-pointer stage
//   and RAM whenever the FIFO is not full. The block also reports the FIFO
//   occupancy seen from the write domain, an almost-full level flag, and a
//   saturating count of cycles in which a buffered word was blocked by full.
//
// Ports:
//   wclk         in   write-domain clock, rising edge
//   wrst_n       in   asynchronous active-low reset
//   s_valid      in   upstream word valid
//   s_data       in   upstream word
//   s_ready      out  registered; a word can be accepted this cycle
//   full         in   registered full flag from the write-pointer stage
//   b_wptr       in   binary write pointer (PTR_WIDTH+1 bits)
//   g_rptr_sync  in   Gray read pointer synchronized into wclk
//   w_en         out  write strobe, combinational
//   wdata        out  oldest buffered word, valid while w_en=1
//   wr_count     out  registered FIFO occupancy
//   almost_full  out  registered; wr_count >= AFULL_THRESH
//   stall_cnt    out  saturating count of blocked cycles
// ---------------------------------------------------------------------------
module wr_flow_ctrl #(
    parameter int PTR_WIDTH    = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int AFULL_THRESH = (1 << PTR_WIDTH) - 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  full,
    input  logic [PTR_WIDTH:0]    b_wptr,
    input  logic [PTR_WIDTH:0]    g_rptr_sync,
    output logic                  w_en,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [PTR_WIDTH:0]    wr_count,
    output logic                  almost_full,
    output logic [15:0]           stall_cnt
);

    localparam logic [PTR_WIDTH:0] LP_AFULL = AFULL_THRESH[PTR_WIDTH:0];

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t                  r_occ;
    occ_t                  w_occNext;
    logic [DATA_WIDTH-1:0] r_entry0;
    logic [DATA_WIDTH-1:0] r_entry1;
    logic                  r_ready;
    logic [PTR_WIDTH:0]    r_count;
    logic                  r_afull;
    logic [15:0]           r_stall;

    logic                  w_push;
    logic                  w_pop;
    logic [PTR_WIDTH:0]    w_rbin;
    logic [PTR_WIDTH:0]    w_diff;

    // Entry 0 is always the oldest word, so it drives the RAM directly.
    assign w_push      = s_valid & r_ready;
    assign w_pop       = (r_occ != OCC_EMPTY) & ~full;
    assign w_en        = w_pop;
    assign wdata       = r_entry0;
    assign s_ready     = r_ready;
    assign wr_count    = r_count;
    assign almost_full = r_afull;
    assign stall_cnt   = r_stall;

    // Occupancy register of the skid buffer.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_occ <= OCC_EMPTY;
        end else begin
            r_occ <= w_occNext;
        end
    end

    // Occupancy next-state. A push into a full buffer cannot happen because
    // ready is low whenever two words are held.
    always_comb begin
        w_occNext = r_occ;
        unique case (r_occ)
            OCC_EMPTY: begin
                if (w_push) w_occNext = OCC_ONE;
            end
            OCC_ONE: begin
                if (w_push && !w_pop)      w_occNext = OCC_TWO;
                else if (!w_push && w_pop) w_occNext = OCC_EMPTY;
            end
            OCC_TWO: begin
                if (w_pop) w_occNext = OCC_ONE;
            end
            default: w_occNext = OCC_EMPTY;
        endcase
    end

    // Buffer storage. On a simultaneous accept and drain the new word slots
    // in behind whatever remains, keeping acceptance order.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_entry0 <= '0;
            r_entry1 <= '0;
        end else begin
            unique case (r_occ)
                OCC_EMPTY: begin
                    if (w_push) r_entry0 <= s_data;
                end
                OCC_ONE: begin
                    if (w_pop) begin
                        if (w_push) r_entry0 <= s_data;
                    end else if (w_push) begin
                        r_entry1 <= s_data;
                    end
                end
                OCC_TWO: begin
                    if (w_pop) r_entry0 <= r_entry1;
                end
                default: begin
                    r_entry0 <= r_entry0;
                end
            endcase
        end
    end

    // Ready is registered from the next occupancy so it drops on the very
    // edge that fills the second entry and rises one edge after reset.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_occNext != OCC_TWO);
        end
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or
    // above its position.
    always_comb begin
        w_rbin = '0;
        for (int i = 0; i <= PTR_WIDTH; i++) begin
            w_rbin[i] = ^(g_rptr_sync >> i);
        end
    end

    // Modular subtraction handles pointer wrap for free.
    assign w_diff = b_wptr - w_rbin;

    // Occupancy and level flag, both from the same cycle's pointers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_count <= '0;
            r_afull <= 1'b0;
        end else begin
            r_count <= w_diff;
            r_afull <= (w_diff >= LP_AFULL);
        end
    end

    // Stall counter: counts edges where a word is held but full blocks it,
    // sticking at all-ones.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_stall <= '0;
        end else if ((r_occ != OCC_EMPTY) && full && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

endmodule

// File: tb/tb_wr_flow_ctrl.sv
// ---------------------------------------------------------------------------
// TbWrFlowCtrl -- self-checking bench for wr_flow_ctrl (PTR_WIDTH=3).
// A queue-based reference model tracks the buffered words, the registered
// ready flag, the occupancy/level outputs and the stall counter.
// ---------------------------------------------------------------------------
module tb_wr_flow_ctrl;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready;
    logic       full = 1'b0;
    logic [3:0] b_wptr = 4'h0;
    logic [3:0] g_rptr_sync = 4'h0;
    logic       w_en;
    logic [7:0] wdata;
    logic [3:0] wr_count;
    logic       almost_full;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  mq[$];
    logic        m_ready = 1'b0;
    logic [3:0]  m_count = 4'h0;
    logic        m_af    = 1'b0;
    logic [15:0] m_stall = 16'h0000;

    wr_flow_ctrl #(
        .PTR_WIDTH (3),
        .DATA_WIDTH(8)
    ) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .full       (full),
        .b_wptr     (b_wptr),
        .g_rptr_sync(g_rptr_sync),
        .w_en       (w_en),
        .wdata      (wdata),
        .wr_count   (wr_count),
        .almost_full(almost_full),
        .stall_cnt  (stall_cnt)
    );

    always #5 wclk = ~wclk;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    // Advance one clock: update the model from the inputs seen at the rising
    // edge, then return at the falling edge where inputs may change.
    task automatic tick();
        int         oldsz;
        logic       push;
        logic       pop;
        logic [7:0] dropped;
        @(posedge wclk);
        if (!wrst_n) begin
            mq.delete();
            m_ready = 1'b0;
            m_count = 4'h0;
            m_af    = 1'b0;
            m_stall = 16'h0000;
        end else begin
            oldsz = mq.size();
            push  = s_valid && m_ready;
            pop   = (oldsz > 0) && !full;
            if (pop) dropped = mq.pop_front();
            if (push) mq.push_back(s_data);
            m_ready = (mq.size() < 2);
            if (oldsz > 0 && full && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            m_count = b_wptr - g2b(g_rptr_sync);
            m_af    = (m_count >= 4'd4);
        end
        @(negedge wclk);
    endtask

    task automatic test_reset();
        wrst_n = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; full = 1'b0;
        b_wptr = 4'h0; g_rptr_sync = 4'h0;
        #1;
        total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b want=0", s_ready); end
        total++; if (w_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wen got=%b want=0", w_en); end
        total++; if (wdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_wdata got=%h want=00", wdata); end
        total++; if (wr_count !== 4'h0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", wr_count); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_af got=%b want=0", almost_full); end
        total++; if (stall_cnt !== 16'h0) begin bad++; $display("[TB] FAIL reset_stall got=%h want=0000", stall_cnt); end
        repeat (2) tick();
        total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_hold_ready got=%b want=0", s_ready); end
        wrst_n = 1'b1;
        tick();
        total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_release_ready got=%b want=1", s_ready); end
        total++; if (w_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_release_wen got=%b want=0", w_en); end
    endtask

    task automatic test_streaming();
        full = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                s_valid = 1'b1; s_data = 8'h10 + 8'(i);
            end else begin
                s_valid = 1'b0;
            end
            #1;
            total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL stream_ready[%0d] got=%b want=1", i, s_ready); end
            if (i > 0) begin
                total++; if (w_en !== 1'b1) begin bad++; $display("[TB] FAIL stream_wen[%0d] got=%b want=1", i, w_en); end
                total++; if (wdata !== 8'h10 + 8'(i - 1)) begin bad++; $display("[TB] FAIL stream_wdata[%0d] got=%h want=%h", i, wdata, 8'h10 + 8'(i - 1)); end
            end
            tick();
        end
        #1;
        total++; if (w_en !== 1'b0) begin bad++; $display("[TB] FAIL stream_idle_wen got=%b want=0", w_en); end
    endtask

    task automatic test_backpressure();
        full = 1'b1; s_valid = 1'b1; s_data = 8'hA0;
        #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready0 got=%b want=1", s_ready); end
        tick();
        s_data = 8'hA1;
        #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready1 got=%b want=1", s_ready); end
        total++; if (w_en !== 1'b0) begin bad++; $display("[TB] FAIL bp_wen1 got=%b want=0", w_en); end
        tick();
        s_data = 8'hA2;
        #1;
        total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready2 got=%b want=0", s_ready); end
        total++; if (w_en !== 1'b0) begin bad++; $display("[TB] FAIL bp_wen2 got=%b want=0", w_en); end
        tick();
        #1;
        total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready3 got=%b want=0", s_ready); end
        total++; if (stall_cnt !== 16'd2) begin bad++; $display("[TB] FAIL bp_stall got=%0d want=2", stall_cnt); end
        s_valid = 1'b0; full = 1'b0;
        #1;
        total++; if (w_en !== 1'b1 || wdata !== 8'hA0) begin bad++; $display("[TB] FAIL bp_drain0 got=%b/%h want=1/a0", w_en, wdata); end
        tick();
        #1;
        total++; if (w_en !== 1'b1 || wdata !== 8'hA1) begin bad++; $display("[TB] FAIL bp_drain1 got=%b/%h want=1/a1", w_en, wdata); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_back got=%b want=1", s_ready); end
        tick();
        #1;
        total++; if (w_en !== 1'b0) begin bad++; $display("[TB] FAIL bp_empty_wen got=%b want=0", w_en); end
    endtask

    task automatic test_simultaneous();
        full = 1'b0; s_valid = 1'b1; s_data = 8'hB0;
        tick();
        s_data = 8'hB1;
        #1;
        total++; if (w_en !== 1'b1 || wdata !== 8'hB0) begin bad++; $display("[TB] FAIL sim_first got=%b/%h want=1/b0", w_en, wdata); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL sim_ready got=%b want=1", s_ready); end
        tick();
        s_valid = 1'b0;
        #1;
        total++; if (w_en !== 1'b1 || wdata !== 8'hB1) begin bad++; $display("[TB] FAIL sim_second got=%b/%h want=1/b1", w_en, wdata); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL sim_ready2 got=%b want=1", s_ready); end
        tick();
        #1;
        total++; if (w_en !== 1'b0) begin bad++; $display("[TB] FAIL sim_empty got=%b want=0", w_en); end
    endtask

    task automatic test_level_wrap();
        logic [3:0] tb_b[5]  = '{4'd2, 4'd2, 4'd4, 4'd5, 4'd1};
        logic [3:0] tb_g[5]  = '{4'b1111, 4'b0011, 4'b0001, 4'b0001, 4'b1101};
        logic [3:0] tb_c[5]  = '{4'd8, 4'd0, 4'd3, 4'd4, 4'd8};
        logic       tb_af[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            b_wptr = tb_b[i]; g_rptr_sync = tb_g[i];
            tick();
            #1;
            total++; if (wr_count !== tb_c[i]) begin bad++; $display("[TB] FAIL level_count[%0d] got=%0d want=%0d", i, wr_count, tb_c[i]); end
            total++; if (almost_full !== tb_af[i]) begin bad++; $display("[TB] FAIL level_af[%0d] got=%b want=%b", i, almost_full, tb_af[i]); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            s_valid     = ($urandom_range(0, 99) < 60);
            s_data      = 8'($urandom);
            full        = ($urandom_range(0, 99) < 30);
            b_wptr      = 4'($urandom);
            g_rptr_sync = 4'($urandom);
            #1;
            total++; if (s_ready !== m_ready) begin bad++; $display("[TB] FAIL rnd_ready[%0d] got=%b want=%b", i, s_ready, m_ready); end
            total++; if (w_en !== ((mq.size() > 0) && !full)) begin bad++; $display("[TB] FAIL rnd_wen[%0d] got=%b want=%b", i, w_en, (mq.size() > 0) && !full); end
            if (mq.size() > 0 && !full) begin
                total++; if (wdata !== mq[0]) begin bad++; $display("[TB] FAIL rnd_wdata[%0d] got=%h want=%h", i, wdata, mq[0]); end
            end
            total++; if (wr_count !== m_count) begin bad++; $display("[TB] FAIL rnd_count[%0d] got=%0d want=%0d", i, wr_count, m_count); end
            total++; if (almost_full !== m_af) begin bad++; $display("[TB] FAIL rnd_af[%0d] got=%b want=%b", i, almost_full, m_af); end
            total++; if (stall_cnt !== m_stall) begin bad++; $display("[TB] FAIL rnd_stall[%0d] got=%0d want=%0d", i, stall_cnt, m_stall); end
            tick();
        end
    endtask

    task automatic test_stall_saturation();
        int guard = 0;
        full = 1'b1; s_valid = 1'b1; s_data = 8'h5A;
        tick();
        s_valid = 1'b0;
        while (m_stall != 16'hFFFE && guard < 70000) begin
            tick();
            guard++;
        end
        #1;
        total++; if (guard >= 70000) begin bad++; $display("[TB] FAIL stall_timeout got=%0d want<70000", guard); end
        total++; if (stall_cnt !== 16'hFFFE) begin bad++; $display("[TB] FAIL stall_fffe got=%h want=fffe", stall_cnt); end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("[TB] FAIL stall_sat[%0d] got=%h want=ffff", i, stall_cnt); end
        end
    endtask

    task automatic test_reset_midstream();
        s_valid = 1'b1; s_data = 8'hC5;
        tick();
        s_valid = 1'b0;
        #1;
        total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_full_ready got=%b want=0", s_ready); end
        #1;
        wrst_n = 1'b0; full = 1'b0;
        #1;
        total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_ready got=%b want=0", s_ready); end
        total++; if (w_en !== 1'b0) begin bad++; $display("[TB] FAIL mid_wen got=%b want=0", w_en); end
        total++; if (wdata !== 8'h00) begin bad++; $display("[TB] FAIL mid_wdata got=%h want=00", wdata); end
        total++; if (wr_count !== 4'h0) begin bad++; $display("[TB] FAIL mid_count got=%0d want=0", wr_count); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("[TB] FAIL mid_af got=%b want=0", almost_full); end
        total++; if (stall_cnt !== 16'h0) begin bad++; $display("[TB] FAIL mid_stall got=%h want=0000", stall_cnt); end
        b_wptr = 4'h0; g_rptr_sync = 4'h0;
        repeat (2) tick();
        wrst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            total++; if (w_en !== 1'b0) begin bad++; $display("[TB] FAIL mid_after_wen[%0d] got=%b want=0", i, w_en); end
            total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_after_ready[%0d] got=%b want=1", i, s_ready); end
        end
        s_valid = 1'b1; s_data = 8'h3C;
        tick();
        s_valid = 1'b0;
        #1;
        total++; if (w_en !== 1'b1 || wdata !== 8'h3C) begin bad++; $display("[TB] FAIL mid_new got=%b/%h want=1/3c", w_en, wdata); end
        tick();
        #1;
        total++; if (w_en !== 1'b0) begin bad++; $display("[TB] FAIL mid_new_empty got=%b want=0", w_en); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_level_wrap();
        test_random();
        test_stall_saturation();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
